// File: rtl/multi_cycle_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes, datapath selects.
// Combinational definitions only; no latency or flow control.
package multi_cycle_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        I_EXEC   = 4'd8,
        I_WB     = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        JAL      = 4'd12,
        JR       = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] FN_JR    = 6'd8;

    localparam logic [1:0] ALUB_B        = 2'd0;
    localparam logic [1:0] ALUB_FOUR     = 2'd1;
    localparam logic [1:0] ALUB_SEXT     = 2'd2;
    localparam logic [1:0] ALUB_SEXT_SH2 = 2'd3;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    localparam logic [1:0] RDST_RT = 2'd0;
    localparam logic [1:0] RDST_RD = 2'd1;
    localparam logic [1:0] RDST_RA = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
    endfunction

endpackage

// File: rtl/mcc_out_dec.sv
// State-to-control table for the multi-cycle controller; purely combinational, zero latency.
// Memory-handshake states qualify their commit strobes with i_mem_rdy; no other stall path.
module mcc_out_dec
    import multi_cycle_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_rdy,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = ALUB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                // IR and PC only commit once the fetched word is actually present
                o_ctrl.ir_write  = i_mem_rdy;
                o_ctrl.pc_write  = i_mem_rdy;
            end
            DECODE: begin
                o_ctrl.alu_src_b = ALUB_SEXT_SH2;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.illegal   = !op_is_legal(i_opcode);
            end
            MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUB_SEXT;
            end
            MEM_RD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = RDST_RT;
                o_ctrl.mem_to_reg = M2R_MDR;
                o_ctrl.instr_done = 1'b1;
            end
            MEM_WR: begin
                o_ctrl.mem_write  = 1'b1;
                o_ctrl.iord       = 1'b1;
                o_ctrl.instr_done = i_mem_rdy;
            end
            R_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUB_B;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = RDST_RD;
                o_ctrl.instr_done = 1'b1;
            end
            I_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUB_SEXT;
            end
            I_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = RDST_RT;
                o_ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
                o_ctrl.instr_done    = 1'b1;
            end
            JUMP: begin
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.pc_source  = PCSRC_JUMP;
                o_ctrl.instr_done = 1'b1;
            end
            JAL: begin
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.pc_source  = PCSRC_JUMP;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = RDST_RA;
                o_ctrl.mem_to_reg = M2R_PC;
                o_ctrl.instr_done = 1'b1;
            end
            JR: begin
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.pc_source  = PCSRC_REG;
                o_ctrl.instr_done = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-style controller: 3-5 cycles per instruction plus memory wait cycles.
// Memory states stall on mem_ready_i (when MEM_HS=1); reset silences every output at once.
module multi_cycle_ctrl
    import multi_cycle_pkg::*;
#(
    parameter bit MEM_HS = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  funct_i,
    input  logic        mem_ready_i,
    output logic        pc_write_o,
    output logic        pc_write_cond_o,
    output logic        iord_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        ir_write_o,
    output logic        reg_write_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  alu_op_o,
    output logic [1:0]  pc_source_o,
    output logic [1:0]  mem_to_reg_o,
    output logic [1:0]  reg_dst_o,
    output logic [3:0]  state_o,
    output logic        instr_done_o,
    output logic        illegal_o,
    output logic [31:0] retired_o
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_retired;
    logic        w_mem_rdy;
    ctrl_t       w_dec;
    ctrl_t       w_ctrl;

    assign w_mem_rdy = MEM_HS ? mem_ready_i : 1'b1;

    mcc_out_dec u_out_dec (
        .i_state   (r_state),
        .i_opcode  (opcode_i),
        .i_mem_rdy (w_mem_rdy),
        .o_ctrl    (w_dec)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:    if (w_mem_rdy) w_next = DECODE;
            DECODE: begin
                case (opcode_i)
                    OP_RTYPE:     w_next = (funct_i == FN_JR) ? JR : R_EXEC;
                    OP_LW, OP_SW: w_next = MEM_ADDR;
                    OP_ADDI:      w_next = I_EXEC;
                    OP_BEQ:       w_next = BRANCH;
                    OP_J:         w_next = JUMP;
                    OP_JAL:       w_next = JAL;
                    default:      w_next = FETCH;
                endcase
            end
            MEM_ADDR: w_next = (opcode_i == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   if (w_mem_rdy) w_next = MEM_WB;
            MEM_WR:   if (w_mem_rdy) w_next = FETCH;
            R_EXEC:   w_next = R_WB;
            I_EXEC:   w_next = I_WB;
            default:  w_next = FETCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_dec.instr_done) r_retired <= r_retired + 32'd1;
        end
    end

    // Reset must blank the outputs in the same cycle, not one edge later
    assign w_ctrl = rst_i ? '0 : w_dec;

    assign pc_write_o      = w_ctrl.pc_write;
    assign pc_write_cond_o = w_ctrl.pc_write_cond;
    assign iord_o          = w_ctrl.iord;
    assign mem_read_o      = w_ctrl.mem_read;
    assign mem_write_o     = w_ctrl.mem_write;
    assign ir_write_o      = w_ctrl.ir_write;
    assign reg_write_o     = w_ctrl.reg_write;
    assign alu_src_a_o     = w_ctrl.alu_src_a;
    assign alu_src_b_o     = w_ctrl.alu_src_b;
    assign alu_op_o        = w_ctrl.alu_op;
    assign pc_source_o     = w_ctrl.pc_source;
    assign mem_to_reg_o    = w_ctrl.mem_to_reg;
    assign reg_dst_o       = w_ctrl.reg_dst;
    assign instr_done_o    = w_ctrl.instr_done;
    assign illegal_o       = w_ctrl.illegal;
    assign state_o         = rst_i ? FETCH : r_state;
    assign retired_o       = rst_i ? '0 : r_retired;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: directed instructions plus random instruction streams
// with random memory waits and reset hits, checked against a per-instruction state-path model.
module tb_multi_cycle_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, mem_ready = 1'b0;
    logic [5:0]  opcode = '0, funct = '0;
    logic        pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o;
    logic        ir_write_o, reg_write_o, alu_src_a_o, instr_done_o, illegal_o;
    logic [1:0]  alu_src_b_o, alu_op_o, pc_source_o, mem_to_reg_o, reg_dst_o;
    logic [3:0]  state_o;
    logic [31:0] retired_o;
    logic [19:0] dut_vec;

    logic        rst2 = 1'b1;
    logic [5:0]  opcode2 = '0, funct2 = '0;
    logic        pcw2, pcc2, iord2, mr2, mw2, irw2, rw2, asa2, done2, ill2;
    logic [1:0]  asb2, aop2, pcs2, m2r2, rd2;
    logic [3:0]  state2;
    logic [31:0] retired2;

    multi_cycle_ctrl #(.MEM_HS(1'b1)) u_dut (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct_i(funct), .mem_ready_i(mem_ready),
        .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .iord_o(iord_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
        .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .alu_op_o(alu_op_o), .pc_source_o(pc_source_o), .mem_to_reg_o(mem_to_reg_o),
        .reg_dst_o(reg_dst_o), .state_o(state_o), .instr_done_o(instr_done_o),
        .illegal_o(illegal_o), .retired_o(retired_o)
    );

    multi_cycle_ctrl #(.MEM_HS(1'b0)) u_dut_nohs (
        .clk_i(clk), .rst_i(rst2), .opcode_i(opcode2), .funct_i(funct2), .mem_ready_i(1'b0),
        .pc_write_o(pcw2), .pc_write_cond_o(pcc2), .iord_o(iord2),
        .mem_read_o(mr2), .mem_write_o(mw2), .ir_write_o(irw2),
        .reg_write_o(rw2), .alu_src_a_o(asa2), .alu_src_b_o(asb2),
        .alu_op_o(aop2), .pc_source_o(pcs2), .mem_to_reg_o(m2r2),
        .reg_dst_o(rd2), .state_o(state2), .instr_done_o(done2),
        .illegal_o(ill2), .retired_o(retired2)
    );

    assign dut_vec = {pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o, ir_write_o,
                      reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_source_o,
                      mem_to_reg_o, reg_dst_o, instr_done_o, illegal_o};

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned exp_ret = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd8, 6'd35, 6'd43};
    endfunction

    // Expected control word for a state, built straight from the per-state output list
    function automatic logic [19:0] exp_vec(input int st, input bit rdy, input logic [5:0] op);
        logic pcw, pcc, io, mr, mw, irw, rw, asa, dn, il;
        logic [1:0] asb, aop, pcs, m2r, rd;
        {pcw, pcc, io, mr, mw, irw, rw, asa, dn, il} = '0;
        {asb, aop, pcs, m2r, rd} = '0;
        case (st)
            0:  begin mr = 1; asb = 1; irw = rdy; pcw = rdy; end
            1:  begin asb = 3; il = !legal(op); end
            2:  begin asa = 1; asb = 2; end
            3:  begin mr = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; dn = 1; end
            5:  begin mw = 1; io = 1; dn = rdy; end
            6:  begin asa = 1; aop = 2; end
            7:  begin rw = 1; rd = 1; dn = 1; end
            8:  begin asa = 1; asb = 2; end
            9:  begin rw = 1; dn = 1; end
            10: begin asa = 1; aop = 1; pcc = 1; pcs = 1; dn = 1; end
            11: begin pcw = 1; pcs = 2; dn = 1; end
            12: begin pcw = 1; pcs = 2; rw = 1; rd = 2; m2r = 2; dn = 1; end
            13: begin pcw = 1; pcs = 3; dn = 1; end
            default: ;
        endcase
        return {pcw, pcc, io, mr, mw, irw, rw, asa, asb, aop, pcs, m2r, rd, dn, il};
    endfunction

    task automatic reset_cycle();
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b1; opcode = 6'h23;
        #1;
        chk("rst_state", {28'd0, state_o}, 32'd0);
        chk("rst_outs", {12'd0, dut_vec}, 32'd0);
        chk("rst_retired", retired_o, 32'd0);
        exp_ret = 0;
    endtask

    // Runs one instruction: fw fetch waits, mw memory waits, reset injected at cycle rst_at (-1 = none)
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, input int rst_at);
        int st_q[$];
        bit rdy_q[$];
        for (int k = 0; k < fw; k++) begin st_q.push_back(0); rdy_q.push_back(1'b0); end
        st_q.push_back(0); rdy_q.push_back(1'b1);
        st_q.push_back(1); rdy_q.push_back(1'($urandom_range(0, 1)));
        if (op == 6'd0 && fn == 6'd8) begin
            st_q.push_back(13); rdy_q.push_back(1'($urandom_range(0, 1)));
        end else if (op == 6'd0) begin
            st_q.push_back(6); rdy_q.push_back(1'($urandom_range(0, 1)));
            st_q.push_back(7); rdy_q.push_back(1'($urandom_range(0, 1)));
        end else if (op == 6'd35 || op == 6'd43) begin
            st_q.push_back(2); rdy_q.push_back(1'($urandom_range(0, 1)));
            for (int k = 0; k < mw; k++) begin
                st_q.push_back(op == 6'd35 ? 3 : 5); rdy_q.push_back(1'b0);
            end
            st_q.push_back(op == 6'd35 ? 3 : 5); rdy_q.push_back(1'b1);
            if (op == 6'd35) begin st_q.push_back(4); rdy_q.push_back(1'($urandom_range(0, 1))); end
        end else if (op == 6'd8) begin
            st_q.push_back(8); rdy_q.push_back(1'($urandom_range(0, 1)));
            st_q.push_back(9); rdy_q.push_back(1'($urandom_range(0, 1)));
        end else if (legal(op)) begin
            st_q.push_back(op == 6'd4 ? 10 : (op == 6'd2 ? 11 : 12));
            rdy_q.push_back(1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < st_q.size(); i++) begin
            if (i == rst_at) begin
                reset_cycle();
                return;
            end
            @(negedge clk);
            rst = 1'b0; opcode = op; funct = fn; mem_ready = rdy_q[i];
            #1;
            chk("state", {28'd0, state_o}, st_q[i]);
            chk("outs", {12'd0, dut_vec}, {12'd0, exp_vec(st_q[i], rdy_q[i], op)});
            chk("retired", retired_o, exp_ret);
        end
        if (legal(op)) exp_ret++;
    endtask

    logic [5:0] ops [8] = '{6'd0, 6'd0, 6'd2, 6'd3, 6'd4, 6'd8, 6'd35, 6'd43};
    int exp_st2 [5] = '{0, 1, 2, 5, 0};

    initial begin
        logic [5:0] op, fn;
        int rat, wr_cnt;

        reset_cycle();
        reset_cycle();

        run_instr(6'd0, 6'h20, 0, 0, -1);
        run_instr(6'd35, 6'd0, 0, 2, -1);
        run_instr(6'd43, 6'd0, 1, 0, -1);
        run_instr(6'd3, 6'd0, 0, 0, -1);
        run_instr(6'd0, 6'd8, 0, 0, -1);
        run_instr(6'h3F, 6'd0, 0, 0, -1);
        run_instr(6'd8, 6'd0, 2, 0, -1);
        run_instr(6'd4, 6'd0, 0, 0, -1);
        run_instr(6'd2, 6'd0, 0, 0, -1);
        run_instr(6'd43, 6'd0, 0, 3, 4);
        run_instr(6'd2, 6'd0, 0, 0, -1);

        for (int n = 0; n < 400; n++) begin
            op  = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 7)];
            fn  = ($urandom_range(0, 3) == 0) ? 6'd8 : 6'($urandom_range(0, 63));
            rat = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), rat);
        end

        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0;
        #1;
        chk("final_retired", retired_o, exp_ret);
        rst = 1'b1;

        // Handshake-free instance: store must finish in 4 cycles with memory never ready
        @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0; opcode2 = 6'd43; funct2 = 6'd0;
        wr_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("nohs_state", {28'd0, state2}, exp_st2[i]);
            if (i < 4) wr_cnt += int'(mw2);
            if (i == 3) chk("nohs_done", {31'd0, done2}, 32'd1);
            @(negedge clk);
        end
        chk("nohs_wr_cycles", wr_cnt, 32'd1);
        chk("nohs_retired", retired2, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Parameter MEM_HS, default 1, meaning: 1 = memory states wait for mem_ready_i; 0 = mem_ready_i is ignored and treated as 1.
REQ-002 clk_i  in  1  single clock; all state changes on the rising edge.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 opcode_i  in  6  instruction-register bits [31:26].
REQ-005 funct_i  in  6  instruction-register bits [5:0].
REQ-006 mem_ready_i  in  1  shared memory completes the current access this cycle.
REQ-007 pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o, ir_write_o, reg_write_o, alu_src_a_o  out  1 each  datapath strobes and selects.
REQ-008 alu_src_b_o  out  2  0 = B, 1 = const 4, 2 = signext, 3 = signext<<2.
REQ-009 alu_op_o  out  2  0 = add, 1 = sub, 2 = decode funct.
REQ-010 pc_source_o  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = A (jr).
REQ-011 mem_to_reg_o  out  2  0 = ALUOut, 1 = MDR, 2 = PC (link).
REQ-012 reg_dst_o  out  2  0 = rt, 1 = rd, 2 = 5'd31.
REQ-013 state_o  out  4  current state; instr_done_o  out  1  last cycle of an instruction; illegal_o  out  1  unknown opcode; retired_o  out  32  count of completed instructions.

Function
REQ-014 The block SHALL be a Moore FSM with the states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JAL and JR; any output not listed for a state SHALL be 0.
REQ-015 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0; ir_write and pc_write are asserted only while mem_ready_i=1; the FSM stays in FETCH until mem_ready_i=1, then goes to DECODE.
REQ-016 DECODE: alu_src_b=3, alu_op=0. Next state: opcode 0 with funct 8 -> JR; other opcode 0 -> R_EXEC; 35 or 43 -> MEM_ADDR; 8 -> I_EXEC; 4 -> BRANCH; 2 -> JUMP; 3 -> JAL; any other opcode -> FETCH with illegal_o=1 for this cycle.
REQ-017 MEM_ADDR: alu_src_a=1, alu_src_b=2; go to MEM_RD if opcode 35, else MEM_WR.
REQ-018 MEM_RD: mem_read=1, iord=1; hold until mem_ready_i, then go to MEM_WB. MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1.
REQ-019 MEM_WR: mem_write=1, iord=1; hold until mem_ready_i, then go to FETCH. mem_write SHALL stay high through every wait cycle.
REQ-020 R_EXEC: alu_src_a=1, alu_src_b=0, alu_op=2. R_WB: reg_write=1, reg_dst=1. I_EXEC: alu_src_a=1, alu_src_b=2. I_WB: reg_write=1, reg_dst=0.
REQ-021 BRANCH: alu_src_a=1, alu_op=1, pc_write_cond=1, pc_source=1.
REQ-022 JUMP: pc_write=1, pc_source=2. JAL: the JUMP outputs plus reg_write=1, reg_dst=2, mem_to_reg=2. JR: pc_write=1, pc_source=3.
REQ-023 MEM_WB, MEM_WR (on its completing cycle), R_WB, I_WB, BRANCH, JUMP, JAL and JR SHALL return to FETCH.
REQ-024 In each of those completing cycles, instr_done_o SHALL be 1 and retired_o SHALL increment on that edge, wrapping from 0xFFFFFFFF to 0.
REQ-025 An illegal opcode SHALL NOT increment retired_o.
REQ-026 Latencies: R-type/addi 4 cycles, lw 5, sw 4, beq/j/jal/jr 3, each plus any memory wait cycles.

Reset
REQ-027 While rst_i=1, every output SHALL be 0 and state_o SHALL be FETCH; rst_i takes priority over mem_ready_i.
REQ-028 rst_i asserted mid-instruction (including during a memory wait) SHALL abandon the instruction without a done pulse and zero retired_o.
REQ-029 The first cycle after rst_i deasserts SHALL be FETCH with mem_read_o=1.

Structure
REQ-030 Package multi_cycle_pkg SHALL hold the state encoding (FETCH=0 through JR=13, in REQ-014 order), the opcode and funct constants, and the alu_src_b, pc_source, mem_to_reg and reg_dst encodings.
REQ-031 The combinational state-to-output table SHALL be one sub-module, mcc_out_dec; the state register, next-state logic and retired counter SHALL remain in the top module.

Verification
REQ-032 Reset, then mem_ready_i held at 1 with opcode 0 and funct 0x20 -> states 0,1,6,7; reg_write=1 and reg_dst=1 in state 7; retired_o=1.
REQ-033 lw (opcode 35) with mem_ready_i low for 2 cycles in MEM_RD -> state sequence 0,1,2,3,3,3,4; mem_read and iord held high through the wait; total 7 cycles.
REQ-034 sw (opcode 43) with MEM_HS=0 and mem_ready_i tied 0 -> completes in 4 cycles; mem_write=1 for exactly 1 cycle.
REQ-035 jal (opcode 3) -> state 12 drives pc_write=1, pc_source=2, reg_dst=2, mem_to_reg=2; jr (opcode 0, funct 8) -> pc_source=3 and reg_write=0.
REQ-036 Opcode 0x3F -> illegal_o high for 1 cycle in DECODE, then FETCH, with retired_o unchanged.
REQ-037 rst_i pulsed during a MEM_WR wait -> next state FETCH, all outputs 0 during the reset cycle, retired_o=0, and no write strobe after reset.
